uart_mmio: RTL and testbench
============================

# uart_mmio

Memory-mapped UART peripheral (8N1) on the data-memory bus of the single-cycle RV32I core. It sits directly downstream of the data-memory address map and decodes the four UART addresses: TX data, RX data, TX done and RX done. It serialises bytes written by the core onto a TX line and deserialises the RX line into a byte register. Reads are combinational, so the core completes each load in one cycle. Status flags let firmware poll for completion.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200). Minimum 4.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr  in  32  data-bus byte address.
- wdata  in  32  store data; only [7:0] is used.
- we  in  1  store strobe.
- re  in  1  load strobe.
- rdata  out  32  load data, combinational, zero-extended.
- uart_sel  out  1  combinational; 1 when addr is in 0x1001_0100..0x1001_0103.
- rx  in  1  serial input, asynchronous to clk.
- tx  out  1  serial output; idles high.

## Operation
- Register map:
  - 0x1001_0100 TX, write-only; reads return 0.
  - 0x1001_0101 RX data, read-only, [7:0].
  - 0x1001_0102 TX_DONE, read-only, bit 0.
  - 0x1001_0103 RX_DONE, read-only, bit 0.
- Stores to read-only addresses have no effect.
- rdata is 0 when uart_sel=0 or re=0.
- TX FSM has states IDLE, START, DATA, STOP. A shared bit counter counts 0..CLKS_PER_BIT-1, and a 3-bit index counts bits.
  - IDLE: tx=1. A store to TX (we & addr==TX) does the following: latch wdata[7:0], clear tx_done, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then set tx_done=1 and return to IDLE.
  - A store to TX while not in IDLE is ignored; the frame in flight is unaffected.
- RX path: rx passes through a 2-flop synchroniser, reset value 1. The RX FSM has states IDLE, START, DATA, STOP.
  - IDLE: a synchronised 0 moves the FSM to START and resets the counter.
  - START: sample at count CLKS_PER_BIT/2-1 (integer division). If the sample is 1, treat it as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, mid-bit; shift in LSB first; 8 samples.
  - STOP: sample mid-bit after CLKS_PER_BIT cycles.
    - Sample 1: load rx_data with the byte, set rx_done=1, go to IDLE.
    - Sample 0 (framing error): discard the byte, leave rx_done and rx_data unchanged, go to IDLE.
- rx_done clear: a load from RX (re & addr==RX) clears rx_done at that clock edge.
  - If a new byte completes on the same edge, the set wins: rx_done=1 and rx_data holds the new byte. The load still returns the old byte, because rdata is combinational.
- Overrun: a new byte overwrites rx_data, and rx_done stays 1. No error flag is kept.
- Reset values:
  - tx=1, tx_done=1, rx_done=0, rx_data=0x00.
  - Both FSMs in IDLE, counters 0.
  - Synchroniser flops = 1.
- Reset mid-frame aborts immediately. tx returns high asynchronously, and any partial RX byte is discarded.

## Timing
- A TX store sampled at edge N drives tx=0 from just after edge N.
- Bit k (k=0..7) is driven during edges N+(k+1)·CLKS_PER_BIT .. N+(k+2)·CLKS_PER_BIT.
- The stop bit starts at edge N+9·CLKS_PER_BIT.
- tx_done=1 after edge N+10·CLKS_PER_BIT; a new TX store is accepted on that edge or later.
- The RX synchroniser adds 2 cycles of latency.
- rx_done rises at the edge that samples the stop bit. For sim this is 2 + 9·CLKS_PER_BIT + CLKS_PER_BIT/2 cycles after the rx falling edge, ±1.
- An RX read clear takes effect at the same edge as the load. rx_done reads 0 on the next cycle unless a new byte completed.
- Back-to-back frames with a 1-bit stop and no idle gap are received without loss.

## Test plan
Sim runs use CLKS_PER_BIT=4 unless a scenario says otherwise.
- Reset: assert rst mid-TX-frame → tx=1, tx_done=1, rx_done=0, rdata@0x1001_0101=0x00.
- TX 0xA5: store 0x000000A5 to 0x1001_0100 → tx produces the bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles wide. tx_done=0 for 40 cycles, then 1. A second store at cycle 20 is ignored.
- RX 0x3C: drive an 8N1 frame of 0x3C on rx → rx_done=1. A load from 0x1001_0101 returns 0x0000003C. A load from 0x1001_0103 returns 1 before the data read and 0 after it.
- Glitch and framing error:
  - A 1-cycle low pulse on rx → no byte, FSM back in IDLE.
  - A frame of 0x55 with a low stop bit → rx_done stays 0 and rx_data is unchanged.
- Overrun and simultaneous set/clear: receive 0x11 then 0x22 without reading → rx_data=0x22. A load from RX on the exact edge 0x33 completes → the load returns 0x22, and afterwards rx_done=1 and rx_data=0x33.
- Decode: for addr=0x1001_0024, uart_sel=0 and rdata=0. For addr=0x1001_0102, uart_sel=1; a store of 0x0 leaves tx_done=1.

Source files
------------

// File: rtl/uart_mmio.sv
// uart_mmio: 8N1 UART on the RV32I data bus. Loads return data combinationally, and TX starts on the edge after the store.
// There is no backpressure. A TX store during a frame is dropped, and firmware polls TX_DONE/RX_DONE.
module uart_mmio #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        uart_sel,
  input  logic        rx,
  output logic        tx
);

  localparam logic [31:0] UART_BASE = 32'h1001_0100;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          tx_state;
  logic [CW-1:0]   tx_cnt;
  logic [2:0]      tx_idx;
  logic [7:0]      tx_shift;
  logic            tx_done;

  state_t          rx_state;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_idx;
  logic [7:0]      rx_shift;
  logic [7:0]      rx_data;
  logic            rx_done;
  logic            rx_s1;
  logic            rx_s2;

  logic            tx_wr;
  logic            rx_rd;
  logic            unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  // The four registers occupy one aligned word, so decode ignores the low two bits.
  assign uart_sel = (addr[31:2] == UART_BASE[31:2]);
  assign tx_wr    = we & uart_sel & (addr[1:0] == 2'd0);
  assign rx_rd    = re & uart_sel & (addr[1:0] == 2'd1);

  always_comb begin
    rdata = 32'd0;
    if (re && uart_sel) begin
      case (addr[1:0])
        2'd1:    rdata = {24'd0, rx_data};
        2'd2:    rdata = {31'd0, tx_done};
        2'd3:    rdata = {31'd0, rx_done};
        default: rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= 3'd0;
      tx_shift <= 8'd0;
      tx       <= 1'b1;
      tx_done  <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx <= 1'b1;
          if (tx_wr) begin
            tx_shift <= wdata[7:0];
            tx_done  <= 1'b0;
            tx       <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            tx_idx   <= 3'd0;
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            tx_done  <= 1'b1;
            tx_state <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= 3'd0;
      rx_shift <= 8'd0;
      rx_data  <= 8'd0;
      rx_done  <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      // A read clear is written first so a byte completing on the same edge overrides it.
      if (rx_rd) begin
        rx_done <= 1'b0;
      end
      case (rx_state)
        S_IDLE: begin
          if (!rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == CNT_MID) begin
            rx_cnt   <= '0;
            rx_idx   <= 3'd0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_idx == 3'd7) begin
              rx_state <= S_STOP;
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
            if (rx_s2) begin
              rx_data <= rx_shift;
              rx_done <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Bench for uart_mmio at 4 clocks per bit. Loads and TX frames are checked by monitors against queued expectations.
module tb_uart_mmio;

  localparam logic [31:0] A_TX     = 32'h1001_0100;
  localparam logic [31:0] A_RX     = 32'h1001_0101;
  localparam logic [31:0] A_TXDONE = 32'h1001_0102;
  localparam logic [31:0] A_RXDONE = 32'h1001_0103;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        uart_sel;
  logic        rx;
  logic        tx;

  int errors = 0;
  int checks = 0;

  logic [32:0] rd_q[$];
  string       nm_q[$];
  logic [7:0]  tx_q[$];

  uart_mmio #(.CLKS_PER_BIT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .rdata    (rdata),
    .uart_sel (uart_sel),
    .rx       (rx),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  // Load monitor: every cycle with re high consumes one expected {uart_sel, rdata}.
  logic [32:0] rd_exp;
  string       rd_nm;
  always @(negedge clk) begin
    if (re) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: addr=%h got sel=%0b rdata=%h, no expectation queued", addr, uart_sel, rdata);
      end else begin
        rd_exp = rd_q.pop_front();
        rd_nm  = nm_q.pop_front();
        if ({uart_sel, rdata} !== rd_exp) begin
          errors++;
          $display("FAIL %s: got sel=%0b rdata=%h, expected sel=%0b rdata=%h",
                   rd_nm, uart_sel, rdata, rd_exp[32], rd_exp[31:0]);
        end
      end
    end
  end

  // TX monitor: every frame must hold each of its 10 bits for exactly 4 cycles.
  logic [7:0] mon_byte;
  logic       mon_bit;
  logic       mon_ok;
  logic       mon_abort;
  initial begin
    forever begin
      @(negedge tx);
      if (!rst) begin
        if (tx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: frame started at %0t, expected none", $time);
          mon_byte = 8'h00;
        end else begin
          mon_byte = tx_q.pop_front();
        end
        mon_abort = 1'b0;
        for (int b = 0; b < 10; b++) begin
          mon_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : mon_byte[b-1];
          mon_ok  = 1'b1;
          for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            if (rst) mon_abort = 1'b1;
            else if (tx !== mon_bit) mon_ok = 1'b0;
          end
          if (mon_abort) break;
          checks++;
          if (!mon_ok) begin
            errors++;
            $display("FAIL tx_bit: byte %h bit %0d not held at %0b for 4 cycles (tx now %0b)",
                     mon_byte, b, mon_bit, tx);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic sel, input logic [31:0] e, input string nm);
    addr = a;
    re   = 1'b1;
    rd_q.push_back({sel, e});
    nm_q.push_back(nm);
    step();
    re   = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(4);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(4);
    end
    rx = stop;
    idle(4);
    rx = 1'b1;
  endtask

  initial begin
    rst = 1'b0; addr = 32'd0; wdata = 32'd0; we = 1'b0; re = 1'b0; rx = 1'b1;
    #1 rst = 1'b1;
    #2 chk("reset_tx", {31'd0, tx}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    rd(A_TXDONE, 1'b1, 32'd1, "reset_tx_done");
    rd(A_RXDONE, 1'b1, 32'd0, "reset_rx_done");
    rd(A_RX,     1'b1, 32'd0, "reset_rx_data");

    // TX 0xA5. The store lands at edge N, and the second store at N+20 must be dropped.
    tx_q.push_back(8'hA5);
    wr(A_TX, 32'h0000_00A5);
    idle(19);
    wr(A_TX, 32'h0000_00FF);
    rd(A_TXDONE, 1'b1, 32'd0, "tx_done_mid");
    idle(17);
    rd(A_TXDONE, 1'b1, 32'd0, "tx_done_n38");
    rd(A_TXDONE, 1'b1, 32'd0, "tx_done_n39");
    rd(A_TXDONE, 1'b1, 32'd1, "tx_done_n40");

    // RX 0x3C
    send(8'h3C, 1'b1);
    idle(2);
    addr = A_RX;
    @(negedge clk);
    chk("rdata_re_low", rdata, 32'd0);
    step();
    rd(A_RXDONE, 1'b1, 32'd1,  "rx3c_done_before");
    rd(A_RX,     1'b1, 32'h3C, "rx3c_data");
    rd(A_RXDONE, 1'b1, 32'd0,  "rx3c_done_after");

    // One-cycle glitch, then a framing error
    rx = 1'b0;
    step();
    rx = 1'b1;
    idle(10);
    rd(A_RXDONE, 1'b1, 32'd0,  "glitch_done");
    rd(A_RX,     1'b1, 32'h3C, "glitch_data");
    send(8'h55, 1'b0);
    idle(3);
    rd(A_RXDONE, 1'b1, 32'd0,  "frame_err_done");
    rd(A_RX,     1'b1, 32'h3C, "frame_err_data");
    send(8'h5A, 1'b1);
    idle(2);
    rd(A_RXDONE, 1'b1, 32'd1,  "recover_done");
    rd(A_RX,     1'b1, 32'h5A, "recover_data");

    // Back-to-back frames overrun the unread byte
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    idle(2);
    rd(A_RXDONE, 1'b1, 32'd1,  "overrun_done");
    rd(A_RX,     1'b1, 32'h22, "overrun_data");

    // The load coincides with the edge that completes 0x33. That edge is 41 cycles after the start bit is driven.
    idle(5);
    fork
      send(8'h33, 1'b1);
      begin
        idle(40);
        rd(A_RX, 1'b1, 32'h22, "setclr_old_data");
      end
    join

    // Decode boundaries, taken while rx_done=1 and rx_data=0x33
    rd(32'h1001_0024, 1'b0, 32'd0, "decode_0024");
    rd(32'h1001_00FF, 1'b0, 32'd0, "decode_00ff");
    rd(32'h1001_0105, 1'b0, 32'd0, "decode_0105");
    rd(A_TX,          1'b1, 32'd0, "tx_reads_zero");
    rd(A_RXDONE,      1'b1, 32'd1,  "setclr_done");
    rd(A_RX,          1'b1, 32'h33, "setclr_new_data");
    wr(A_TXDONE, 32'd0);
    idle(2);
    rd(A_TXDONE, 1'b1, 32'd1, "ro_store_tx_done");

    // Put a byte back in rx_data, then reset in the middle of a TX frame
    send(8'h7E, 1'b1);
    idle(2);
    tx_q.push_back(8'hC3);
    wr(A_TX, 32'h0000_00C3);
    idle(15);
    rst = 1'b1;
    #2 chk("reset_mid_tx", {31'd0, tx}, 32'd1);
    idle(2);
    rst = 1'b0;
    step();
    rd(A_TXDONE, 1'b1, 32'd1, "reset_mid_tx_done");
    rd(A_RXDONE, 1'b1, 32'd0, "reset_mid_rx_done");
    rd(A_RX,     1'b1, 32'd0, "reset_mid_rx_data");
    idle(50);

    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    chk("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
